// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants, state encoding and frame payload for the register-file dump reader.
//   DUMP_FRAME_BYTES : bytes per register frame (index byte + 4 data bytes)
//   dump_state_e     : controller states
//   dump_frame_t     : payload handed to the frame serializer
//   frame_byte()     : byte selector for a frame position
package regfile_dump_reader_pkg;

    localparam int unsigned DUMP_FRAME_BYTES = 5;
    localparam int unsigned BYTE_CNT_W       = 3;

    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'd0,
        DUMP_LATCH = 2'd1,
        DUMP_SEND  = 2'd2,
        DUMP_DONE  = 2'd3
    } dump_state_e;

    typedef struct packed {
        logic [7:0]  idx_byte;
        logic [31:0] data;
    } dump_frame_t;

    // Frame order: index byte, then data most-significant byte first.
    function automatic logic [7:0] frame_byte(input logic [BYTE_CNT_W-1:0] sel,
                                              input dump_frame_t f);
        case (sel)
            3'd0:    frame_byte = f.idx_byte;
            3'd1:    frame_byte = f.data[31:24];
            3'd2:    frame_byte = f.data[23:16];
            3'd3:    frame_byte = f.data[15:8];
            3'd4:    frame_byte = f.data[7:0];
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Debug read port plus outgoing byte stream of the dump reader.
//   rf_raddr / rf_rdata : combinational register-file debug read port
//   tx_data / tx_valid / tx_ready : valid/ready byte stream toward UART/VGA debug path
// master = dump reader, slave = register file + stream sink.
interface regfile_dump_reader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rf_raddr, tx_data, tx_valid,
        input  rf_rdata, tx_ready
    );

    modport slave (
        input  rf_raddr, tx_data, tx_valid,
        output rf_rdata, tx_ready
    );
endinterface

// File: rtl/regfile_dump_reader_ser.sv
// Frame serializer: emits one 5-byte frame on a valid/ready stream.
//   clk, rst         : clock, async active-high reset
//   load             : start a new frame (index byte comes from frame.idx_byte)
//   flush            : drop the rest of the frame once the current byte is accepted
//   frame            : index byte + data word (data read from byte 1 onward)
//   tx_ready         : sink ready
//   tx_data/tx_valid : stream outputs, held stable until accepted
//   accepted_c       : current byte accepted this cycle
//   last_accepted_c  : final byte of the frame accepted this cycle
module regfile_dump_reader_ser
    import regfile_dump_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  dump_frame_t frame,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        accepted_c,
    output logic        last_accepted_c
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(DUMP_FRAME_BYTES - 1);

    logic [BYTE_CNT_W-1:0] byte_cnt;

    assign accepted_c      = tx_valid && tx_ready;
    assign last_accepted_c = accepted_c && (byte_cnt == LAST_BYTE);

    // Byte 0 depends only on the index, so it can be loaded on the same edge
    // that captures the data word; later bytes read the already-captured word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (load) begin
            byte_cnt <= '0;
            tx_data  <= frame_byte(BYTE_CNT_W'(0), frame);
            tx_valid <= 1'b1;
        end else if (accepted_c) begin
            if (byte_cnt == LAST_BYTE || flush) begin
                byte_cnt <= '0;
                tx_data  <= 8'h00;
                tx_valid <= 1'b0;
            end else begin
                byte_cnt <= BYTE_CNT_W'(byte_cnt + 1'b1);
                tx_data  <= frame_byte(BYTE_CNT_W'(byte_cnt + 1'b1), frame);
            end
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug reader that walks the register file through its debug read port and
// streams every register as a frame {idx, d[31:24], d[23:16], d[15:8], d[7:0]}.
//   clk, rst : clock, async active-high reset
//   start    : one-cycle dump request, ignored while busy
//   abort    : cancel; immediate in LATCH, after the current byte in SEND
//   busy     : dump in progress
//   done     : one-cycle pulse after the last byte of the last frame
//   bus      : read port + byte stream (master side)
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SKIP_X0  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master bus
);

    // Frame layout assumes a 32-bit word and an index that fits the index byte.
    if (DATA_W != 32 || ADDR_W == 0 || ADDR_W > 8 || NUM_REGS > (32'd1 << ADDR_W)) begin : g_bad_params
        $error("regfile_dump_reader: unsupported DATA_W/ADDR_W/NUM_REGS combination");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : ADDR_W'(0);

    dump_state_e       state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              abort_pend, abort_pend_nxt;
    logic [DATA_W-1:0] shadow;
    logic              busy_nxt, done_nxt;
    logic [ADDR_W-1:0] raddr_nxt;
    logic              load, flush;
    logic              accepted_c, last_accepted_c;
    dump_frame_t       frame;

    assign frame = '{idx_byte: 8'(idx), data: 32'(shadow)};

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DUMP_IDLE;
            idx          <= '0;
            abort_pend   <= 1'b0;
            shadow       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.rf_raddr <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            abort_pend   <= abort_pend_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            bus.rf_raddr <= raddr_nxt;
            // Sampled at the end of LATCH: a write on that same edge is not seen.
            if (state == DUMP_LATCH) begin
                shadow <= bus.rf_rdata;
            end
        end
    end

    // Next-state, index and pending-abort logic.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        abort_pend_nxt = abort_pend;
        case (state)
            DUMP_IDLE: begin
                abort_pend_nxt = 1'b0;
                if (start && !abort) begin
                    state_nxt = DUMP_LATCH;
                    idx_nxt   = FIRST_IDX;
                end
            end
            DUMP_LATCH: begin
                state_nxt = abort ? DUMP_IDLE : DUMP_SEND;
            end
            DUMP_SEND: begin
                if (abort) begin
                    abort_pend_nxt = 1'b1;
                end
                if (accepted_c && (abort || abort_pend)) begin
                    state_nxt      = DUMP_IDLE;
                    abort_pend_nxt = 1'b0;
                end else if (last_accepted_c) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DUMP_DONE;
                    end else begin
                        idx_nxt   = ADDR_W'(idx + 1'b1);
                        state_nxt = DUMP_LATCH;
                    end
                end
            end
            DUMP_DONE: begin
                state_nxt = DUMP_IDLE;
            end
            default: begin
                state_nxt = DUMP_IDLE;
            end
        endcase
    end

    // Output next values and serializer controls.
    always_comb begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        raddr_nxt = '0;
        load      = 1'b0;
        flush     = 1'b0;
        busy_nxt  = (state_nxt == DUMP_LATCH) || (state_nxt == DUMP_SEND);
        done_nxt  = (state_nxt == DUMP_DONE);
        if (state_nxt == DUMP_LATCH) begin
            raddr_nxt = idx_nxt;
        end
        load  = (state == DUMP_LATCH) && (state_nxt == DUMP_SEND);
        flush = (state == DUMP_SEND) && (abort || abort_pend);
    end

    regfile_dump_reader_ser u_ser (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .flush           (flush),
        .frame           (frame),
        .tx_ready        (bus.tx_ready),
        .tx_data         (bus.tx_data),
        .tx_valid        (bus.tx_valid),
        .accepted_c      (accepted_c),
        .last_accepted_c (last_accepted_c)
    );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps, skip-x0 variant, random
// back-pressure, abort, read-before-write snapshot, restart-while-busy and reset.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic abort0 = 1'b0;
    logic ready0 = 1'b1;
    logic ready1 = 1'b1;
    logic busy0, done0, busy1, done1;

    logic        init = 1'b0;
    logic        we   = 1'b0;
    logic [4:0]  wa   = 5'd0;
    logic [31:0] wd   = 32'd0;
    logic [31:0] regs [0:31];

    int n_cmp = 0;
    int n_err = 0;
    int hold_viol = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();
    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus1 ();

    assign bus0.tx_ready = ready0;
    assign bus1.tx_ready = ready1;
    assign bus0.rf_rdata = regs[bus0.rf_raddr];
    assign bus1.rf_rdata = regs[bus1.rf_raddr];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .bus(bus0)
    );

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .busy(busy1), .done(done1), .bus(bus1)
    );

    // Register file model with a single write port (read-before-write).
    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'hA000_0000 + 32'(k);
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Stream monitor: collect accepted bytes, count done pulses, watch hold rule.
    always @(posedge clk) begin
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (bus0.tx_valid && bus0.tx_ready) q0.push_back(bus0.tx_data);
            if (bus1.tx_valid && bus1.tx_ready) q1.push_back(bus1.tx_data);
            if (hold_v && !(bus0.tx_valid && bus0.tx_data == hold_d)) hold_viol <= hold_viol + 1;
            hold_v <= bus0.tx_valid && !bus0.tx_ready;
            hold_d <= bus0.tx_data;
            if (done0) done_cnt0 <= done_cnt0 + 1;
            if (done1) done_cnt1 <= done_cnt1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // Wait until byte number n of the dump is being presented on the stream.
    task automatic wait_present(input string tag, input int n, input int budget);
        int k = 0;
        while (!(q0.size() == n && bus0.tx_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(k < budget), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!done0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 64'(cyc < budget), 64'd1);
    endtask

    // Every frame f of q0 must be {k, A0, 00, 00, k} with k = first + f.
    task automatic chk_frames(input string tag, input int first, input int nfr);
        chk({tag, "_len"}, 64'(q0.size()), 64'(5 * nfr));
        for (int f = 0; f < nfr && 5 * f + 4 < q0.size(); f++) begin
            chk(tag, 64'({q0[5*f], q0[5*f+1], q0[5*f+2], q0[5*f+3], q0[5*f+4]}),
                64'({8'(first + f), 32'hA000_0000 + 32'(first + f)}));
        end
    endtask

    initial begin
        int t0;
        int t1;
        int d0;
        int d1;
        int cyc;
        int hv;
        logic seen;

        // Reset state
        init = 1'b1;
        repeat (3) @(negedge clk);
        init = 1'b0;
        chk("rst_tx_valid", 64'(bus0.tx_valid), 64'd0);
        chk("rst_tx_data",  64'(bus0.tx_data),  64'd0);
        chk("rst_busy",     64'(busy0),         64'd0);
        chk("rst_done",     64'(done0),         64'd0);
        chk("rst_raddr",    64'(bus0.rf_raddr), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1 + 2: full dumps with ready=1, SKIP_X0=0 and SKIP_X0=1 side by side
        q0.delete(); q1.delete();
        d0 = done_cnt0; d1 = done_cnt1;
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        chk("t1_busy_n1",   64'(busy0),         64'd1);
        chk("t2_busy_n1",   64'(busy1),         64'd1);
        chk("t1_valid_n1",  64'(bus0.tx_valid), 64'd0);
        chk("t1_raddr_n1",  64'(bus0.rf_raddr), 64'd0);
        chk("t2_raddr_n1",  64'(bus1.rf_raddr), 64'd1);
        @(negedge clk);
        chk("t1_valid_n2",  64'(bus0.tx_valid), 64'd1);
        chk("t1_data_n2",   64'(bus0.tx_data),  64'h00);
        chk("t2_data_n2",   64'(bus1.tx_data),  64'h01);
        t0 = 0; t1 = 0;
        for (int n = 3; n <= 200; n++) begin
            @(negedge clk);
            if (done0 && t0 == 0) t0 = n;
            if (done1 && t1 == 0) t1 = n;
        end
        chk("t1_done_cycle", 64'(t0), 64'd193);
        chk("t2_done_cycle", 64'(t1), 64'd187);
        chk("t1_done_count", 64'(done_cnt0 - d0), 64'd1);
        chk("t2_done_count", 64'(done_cnt1 - d1), 64'd1);
        chk("t1_busy_after", 64'(busy0), 64'd0);
        chk_frames("t1_frame", 0, 32);
        chk("t2_len",        64'(q1.size()), 64'd155);
        if (q1.size() == 155) begin
            chk("t2_first_byte", 64'(q1[0]),   64'h01);
            chk("t2_last_byte",  64'(q1[154]), 64'h1F);
        end

        // Test 3: random back-pressure
        q0.delete();
        d0 = done_cnt0; hv = hold_viol;
        pulse_start0();
        seen = 1'b0;
        for (int n = 0; n < 1200 && !seen; n++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
            else ready0 = 1'($urandom_range(0, 1));
        end
        ready0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_done_seen",  64'(seen), 64'd1);
        chk("t3_done_count", 64'(done_cnt0 - d0), 64'd1);
        chk("t3_hold_viol",  64'(hold_viol - hv), 64'd0);
        chk_frames("t3_frame", 0, 32);

        // Test 4: abort during byte 2 of frame 7 with 3 stalled cycles
        q0.delete();
        d0 = done_cnt0; hv = hold_viol;
        pulse_start0();
        wait_present("t4_reach", 37, 400);
        ready0 = 1'b0;
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("t4_busy_pending",  64'(busy0),         64'd1);
        chk("t4_valid_pending", 64'(bus0.tx_valid), 64'd1);
        chk("t4_data_pending",  64'(bus0.tx_data),  64'h00);
        repeat (2) @(negedge clk);
        ready0 = 1'b1;
        @(negedge clk);
        chk("t4_valid_after", 64'(bus0.tx_valid), 64'd0);
        chk("t4_busy_after",  64'(busy0),         64'd0);
        repeat (5) @(negedge clk);
        chk("t4_len",        64'(q0.size()), 64'd38);
        if (q0.size() >= 38) begin
            chk("t4_byte1", 64'(q0[36]), 64'hA0);
            chk("t4_byte2", 64'(q0[37]), 64'h00);
        end
        chk("t4_no_done",    64'(done_cnt0 - d0), 64'd0);
        chk("t4_hold_viol",  64'(hold_viol - hv), 64'd0);
        q0.delete();
        pulse_start0();
        wait_done("t4_restart_done", 400, cyc);
        chk("t4_restart_latency", 64'(cyc + 1), 64'd193);
        repeat (2) @(negedge clk);
        chk_frames("t4_restart_frame", 0, 32);

        // Test 5a: write x5 during its LATCH cycle -> old value
        q0.delete();
        pulse_start0();
        for (int n = 0; n < 100 && bus0.rf_raddr != 5'd5; n++) @(negedge clk);
        chk("t5a_latch_x5", 64'(bus0.rf_raddr), 64'd5);
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0;
        wait_done("t5a_done", 400, cyc);
        repeat (2) @(negedge clk);
        if (q0.size() >= 30)
            chk("t5a_frame5", 64'({q0[25], q0[26], q0[27], q0[28], q0[29]}), 64'h05_A000_0005);
        we = 1'b1; wa = 5'd5; wd = 32'hA000_0005;
        @(negedge clk);
        we = 1'b0;

        // Test 5b: write x5 one cycle before its LATCH -> new value
        q0.delete();
        pulse_start0();
        wait_present("t5b_reach", 24, 400);
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0;
        wait_done("t5b_done", 400, cyc);
        repeat (2) @(negedge clk);
        if (q0.size() >= 30)
            chk("t5b_frame5", 64'({q0[25], q0[26], q0[27], q0[28], q0[29]}), 64'h05_DEAD_BEEF);
        we = 1'b1; wa = 5'd5; wd = 32'hA000_0005;
        @(negedge clk);
        we = 1'b0;

        // Test 6: start while busy is ignored, then reset mid-frame 3
        q0.delete();
        pulse_start0();
        wait_present("t6_reach_f2", 12, 200);
        pulse_start0();
        chk("t6_busy_restart",  64'(busy0),         64'd1);
        chk("t6_valid_restart", 64'(bus0.tx_valid), 64'd1);
        wait_present("t6_reach_f3", 16, 200);
        if (q0.size() >= 16) chk("t6_frame3_idx", 64'(q0[15]), 64'h03);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(bus0.tx_valid), 64'd0);
        chk("t6_rst_data",  64'(bus0.tx_data),  64'd0);
        chk("t6_rst_busy",  64'(busy0),         64'd0);
        chk("t6_rst_done",  64'(done0),         64'd0);
        chk("t6_rst_raddr", 64'(bus0.rf_raddr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_valid", 64'(bus0.tx_valid), 64'd0);
        chk("t6_idle_busy",  64'(busy0),         64'd0);
        chk("t6_len",        64'(q0.size()),     64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
